// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths and encodings, the fetch FSM state,
// and the IF/ID register layout used by decode.
package fetch_pkg;

    localparam int              PC_WIDTH    = 8;
    localparam int              INSTR_WIDTH = 8;
    localparam int              CNT_WIDTH   = 16;
    localparam logic [7:0]      RESET_PC    = 8'h00;
    localparam logic [7:0]      HALT_OPCODE = 8'hFF;
    localparam logic [7:0]      NOP_OPCODE  = 8'h00;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
        logic                   valid;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: load has priority over increment, otherwise hold.
// Increment wraps modulo 2^PC_WIDTH.
module fetch_pc_reg #(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_value,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples its inputs from before the edge regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + PC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the instruction memory address, captures the returned word into
// the IF/ID register, and handles stall, redirect-with-bubble and halt.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     PC_WIDTH    = fetch_pkg::PC_WIDTH,
    parameter int                     INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = fetch_pkg::RESET_PC,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE,
    parameter logic [INSTR_WIDTH-1:0] NOP_OPCODE  = fetch_pkg::NOP_OPCODE,
    parameter int                     CNT_WIDTH   = fetch_pkg::CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   jump_en,
    input  logic [PC_WIDTH-1:0]    jump_target,
    output logic [PC_WIDTH-1:0]    pc,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic                   if_valid,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    fetch_state_t state_q, state_d;

    logic pc_load;
    logic pc_inc;
    logic ifid_capture;
    logic ifid_flush;
    logic ifid_retire;

    fetch_pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .load_value (jump_target),
        .inc        (pc_inc),
        .pc         (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        ifid_capture = 1'b0;
        ifid_flush   = 1'b0;
        ifid_retire  = 1'b0;

        if (jump_en) begin
            // Redirect wins over stall and halt; the word now on the bus is dropped.
            pc_load    = 1'b1;
            ifid_flush = 1'b1;
            state_d    = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        ifid_capture = 1'b1;
                        if (instruction == HALT_OPCODE) begin
                            state_d = HALT;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                end
                HALT: begin
                    ifid_retire = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_instr <= NOP_OPCODE;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else if (ifid_flush) begin
            if_instr <= NOP_OPCODE;
            if_valid <= 1'b0;
        end else if (ifid_capture) begin
            if_instr <= instruction;
            if_pc    <= pc;
            if_valid <= 1'b1;
        end else if (ifid_retire) begin
            if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (ifid_capture && (fetch_count != '1)) begin
            fetch_count <= fetch_count + CNT_WIDTH'(1);
        end
    end

    assign halted = (state_q == HALT);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Read-side initiator for the 8-bit combinational instruction memory.
- Owns the program counter, drives the memory address, and captures the returned instruction into an IF/ID register for decode.
- Supports stall, jump/branch redirect with a one-bubble flush, and halt detection.
- Keeps a saturating count of fetched instructions for bring-up and debug.

Parameters:
- PC_WIDTH, 8, width of the program counter and memory address.
- INSTR_WIDTH, 8, width of an instruction word.
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_OPCODE, 8'hFF, instruction encoding that stops fetch.
- NOP_OPCODE, 8'h00, value placed in the IF/ID register on a flush bubble.
- CNT_WIDTH, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and IF/ID register (back-pressure from decode).
- jump_en  input  1  redirect fetch this cycle.
- jump_target  input  PC_WIDTH  redirect address, valid when jump_en=1.
- pc  output  PC_WIDTH  address to instruction memory; registered.
- instruction  input  INSTR_WIDTH  memory read data; combinational function of pc, same cycle.
- if_instr  output  INSTR_WIDTH  IF/ID register: captured instruction.
- if_pc  output  PC_WIDTH  IF/ID register: address of if_instr.
- if_valid  output  1  if_instr is a real instruction, not a bubble.
- halted  output  1  fetch is stopped on HALT_OPCODE.
- fetch_count  output  CNT_WIDTH  number of valid instructions captured; saturating.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - pc=RESET_PC, if_instr=NOP_OPCODE, if_pc=0, if_valid=0, halted=0, fetch_count=0.
  - FSM returns to RUN.
  - Reset mid-jump or mid-stall discards the pending action.
- FSM states:
  - RUN: fetching.
  - HALT: fetch stopped.
  - RUN -> HALT when a HALT_OPCODE is captured.
  - HALT -> RUN only on jump_en or reset.
- Per-edge priority in RUN is reset > jump_en > stall > normal fetch.
- Normal fetch (RUN, no stall, no jump):
  - if_instr<=instruction, if_pc<=pc, if_valid<=1.
  - pc<=pc+1, modulo 2^PC_WIDTH, so 8'hFF wraps to 8'h00 with no flag.
  - fetch_count<=fetch_count+1, saturating at all-ones.
  - Fetch latency: the instruction at address A appears on if_instr one edge after pc=A.
- Jump (jump_en=1, either state, overrides stall):
  - pc<=jump_target, if_instr<=NOP_OPCODE, if_valid<=0, halted<=0, state<=RUN.
  - fetch_count is unchanged.
  - The instruction currently on the memory bus is discarded, giving exactly one bubble.
  - Back-to-back jumps produce consecutive bubbles; the last target wins.
- Stall (stall=1, no jump):
  - pc, if_instr, if_pc, if_valid and fetch_count all hold.
  - A stall in HALT has no effect.
- Halt capture: if the captured instruction equals HALT_OPCODE:
  - if_instr<=HALT_OPCODE, if_valid<=1, fetch_count increments.
  - pc is NOT incremented and stays at the halt address.
  - halted<=1, state<=HALT.
- In HALT (no jump): if_valid<=0 from the next edge; pc, if_pc and if_instr hold; fetch_count holds.
- Simultaneous jump_en and a HALT_OPCODE on instruction: the jump wins, and the halt is not captured.
- Simultaneous stall and a HALT_OPCODE on instruction: the stall wins; the halt is captured only when stall deasserts.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package fetch_pkg holds:
  - PC_WIDTH, INSTR_WIDTH, NOP_OPCODE, HALT_OPCODE, RESET_PC;
  - the fetch_state_t enum {RUN, HALT};
  - an if_id_t struct {instr, pc, valid} reused by decode.
- One natural sub-module, fetch_pc_reg: the PC register with load, hold and increment controls, wrap-around, and async reset.
- The FSM, IF/ID register and counter stay in the top level.

Test Plan:
- Reset release with memory holding 8'h10 at address 0 and 8'h11 at address 1, no stall -> after edge 1: pc=1, if_instr=8'h10, if_pc=0, if_valid=1; after edge 2: if_instr=8'h11, fetch_count=2.
- Wrap: jump_target=8'hFE, then 3 free-running edges -> pc goes 8'hFE, FF, 00, 01; if_pc follows FE, FF, 00 on consecutive edges.
- Stall held 3 cycles at pc=8'h05 -> pc, if_instr, if_pc and fetch_count are unchanged; resume -> if_pc=5 on the next edge.
- jump_en with jump_target=8'h40 while stall=1 at pc=8'h07 -> next edge: pc=8'h40, if_valid=0, if_instr=8'h00; following edge: if_pc=8'h40, if_valid=1.
- 8'hFF stored at address 8'h03 -> edge after pc=3: halted=1, if_instr=8'hFF, if_valid=1, pc=3; next edge if_valid=0; jump_en to 8'h00 -> halted=0, fetch resumes.
- Assert reset asynchronously between edges while at pc=8'h20 with fetch_count=9 -> outputs go to reset values immediately, without a clock edge.
